// File: rtl/conv_layer_stream.sv
// conv_layer_stream
//   Multi-channel, multi-filter 1-D convolution layer. A frame is latched on a
//   valid/ready handshake. One accumulator per filter then steps through the
//   kernel taps (channel innermost, then kernel row) for each output position.
//   Each finished position is floored, saturated and optionally ReLU-clamped
//   into a registered result array. The whole array is presented under
//   valid_o/ready_i.
//
// Ports
//   clk_i     : clock
//   reset_i   : asynchronous, active-high reset
//   valid_i   : input frame valid
//   ready_o   : block can accept a frame (IDLE and not in reset)
//   data_i    : [IH][IC] signed input words
//   kernel_i  : [NF][KH][IC] signed kernel words
//   bias_i    : [NF] signed per-filter bias
//   valid_o   : data_o holds a complete result
//   ready_i   : downstream accepts the result
//   data_o    : [NF][OH] signed result words
module conv_layer_stream #(
  parameter int INPUT_LAYER_HEIGHT = 8,
  parameter int INPUT_CHANNELS     = 2,
  parameter int KERNEL_HEIGHT      = 3,
  parameter int NUM_FILTERS        = 4,
  parameter int STRIDE             = 1,
  parameter int WORD_SIZE          = 16,
  parameter int FRAC_BITS          = 8,
  parameter int RELU               = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic valid_i,
  output logic ready_o,
  input  logic [INPUT_LAYER_HEIGHT-1:0][INPUT_CHANNELS-1:0][WORD_SIZE-1:0] data_i,
  input  logic [NUM_FILTERS-1:0][KERNEL_HEIGHT-1:0][INPUT_CHANNELS-1:0][WORD_SIZE-1:0] kernel_i,
  input  logic [NUM_FILTERS-1:0][WORD_SIZE-1:0] bias_i,
  output logic valid_o,
  input  logic ready_i,
  output logic [NUM_FILTERS-1:0][(INPUT_LAYER_HEIGHT-KERNEL_HEIGHT)/STRIDE:0][WORD_SIZE-1:0] data_o
);

  localparam int IH    = INPUT_LAYER_HEIGHT;
  localparam int IC    = INPUT_CHANNELS;
  localparam int KH    = KERNEL_HEIGHT;
  localparam int NF    = NUM_FILTERS;
  localparam int W     = WORD_SIZE;
  localparam int PW    = 2 * W;
  localparam int OH    = (IH - KH) / STRIDE + 1;
  localparam int ACC_W = 2 * W + $clog2(KH * IC + 1) + 1;
  localparam int POS_W = (OH > 1) ? $clog2(OH) : 1;
  localparam int K_W   = (KH > 1) ? $clog2(KH) : 1;
  localparam int C_W   = (IC > 1) ? $clog2(IC) : 1;
  localparam int ROW_W = (IH > 1) ? $clog2(IH) : 1;

  if ((IH - KH) % STRIDE != 0) begin : g_stride_check
    $error("conv_layer_stream: (INPUT_LAYER_HEIGHT-KERNEL_HEIGHT) must be a multiple of STRIDE");
  end
  if (FRAC_BITS >= W) begin : g_frac_check
    $error("conv_layer_stream: FRAC_BITS must be smaller than WORD_SIZE");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  typedef logic signed [W-1:0]     word_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Output range expressed at accumulator width so the clamp compares are exact.
  localparam acc_t  SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam acc_t  SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam word_t MAX_W   = {1'b0, {(W-1){1'b1}}};
  localparam word_t MIN_W   = {1'b1, {(W-1){1'b0}}};

  state_t                        state_q, state_d;
  logic [POS_W-1:0]              pos_q, pos_d;
  logic [K_W-1:0]                k_q, k_d;
  logic [C_W-1:0]                c_q, c_d;
  acc_t                          acc_q [NF];
  acc_t                          acc_d [NF];
  logic [NF-1:0][OH-1:0][W-1:0]  data_o_q, data_o_d;

  word_t data_q   [IH][IC];
  word_t kernel_q [NF][KH][IC];
  word_t bias_q   [NF];

  logic                 accept;
  logic                 last_tap;
  logic                 last_pos;
  logic [ROW_W-1:0]     row_idx;
  logic signed [PW-1:0] prod    [NF];
  acc_t                 acc_sum [NF];

  // Bias enters the accumulator in the product's Q(2*FRAC_BITS) scale.
  function automatic acc_t bias_ext(input word_t b);
    return acc_t'(b) <<< FRAC_BITS;
  endfunction

  // Floor to Q(FRAC_BITS), clamp to the word range, then optional ReLU.
  function automatic word_t convert(input acc_t a);
    acc_t  s;
    word_t r;
    s = a >>> FRAC_BITS;
    if (s > SAT_MAX)      r = MAX_W;
    else if (s < SAT_MIN) r = MIN_W;
    else                  r = s[W-1:0];
    if (RELU != 0 && r[W-1]) r = '0;
    return r;
  endfunction

  assign ready_o  = (state_q == IDLE) && !reset_i;
  assign valid_o  = (state_q == DONE);
  assign data_o   = data_o_q;
  assign accept   = valid_i && ready_o;
  assign row_idx  = ROW_W'(int'(pos_q) * STRIDE + int'(k_q));
  assign last_tap = (k_q == K_W'(KH - 1)) && (c_q == C_W'(IC - 1));
  assign last_pos = (pos_q == POS_W'(OH - 1));

  // One full-width signed product per filter for the current tap.
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      prod[f]    = PW'(data_q[row_idx][c_q]) * PW'(kernel_q[f][k_q][c_q]);
      acc_sum[f] = acc_q[f] + acc_t'(prod[f]);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    pos_d    = pos_q;
    k_d      = k_q;
    c_d      = c_q;
    data_o_d = data_o_q;
    for (int f = 0; f < NF; f++) acc_d[f] = acc_q[f];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = COMPUTE;
          pos_d   = '0;
          k_d     = '0;
          c_d     = '0;
          for (int f = 0; f < NF; f++) acc_d[f] = bias_ext(bias_i[f]);
        end
      end
      COMPUTE: begin
        if (last_tap) begin
          // The final tap is folded straight into the written result, so the
          // position completes on the same edge as its last product.
          for (int f = 0; f < NF; f++) begin
            data_o_d[f][pos_q] = convert(acc_sum[f]);
            acc_d[f]           = bias_ext(bias_q[f]);
          end
          k_d = '0;
          c_d = '0;
          if (last_pos) begin
            pos_d   = '0;
            state_d = DONE;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          for (int f = 0; f < NF; f++) acc_d[f] = acc_sum[f];
          if (c_q == C_W'(IC - 1)) begin
            c_d = '0;
            k_d = k_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      k_q      <= '0;
      c_q      <= '0;
      data_o_q <= '0;
      for (int f = 0; f < NF; f++) acc_q[f] <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      k_q      <= k_d;
      c_q      <= c_d;
      data_o_q <= data_o_d;
      for (int f = 0; f < NF; f++) acc_q[f] <= acc_d[f];
    end
  end

  // NOTE: operand storage has no reset; it is always loaded on accept before COMPUTE reads it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IC; c++)
          data_q[r][c] <= data_i[r][c];
      for (int f = 0; f < NF; f++) begin
        bias_q[f] <= bias_i[f];
        for (int k = 0; k < KH; k++)
          for (int c = 0; c < IC; c++)
            kernel_q[f][k][c] <= kernel_i[f][k][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Testbench for conv_layer_stream.
// dut_a (defaults, RELU=1) and dut_b (RELU=0) share one input stream and run
// in lockstep. dut_c uses IH=9 and STRIDE=2. Expected results come from a
// plain-arithmetic convolution model working on integer arrays.
module tb_conv_layer_stream;

  typedef logic signed [15:0] word_t;
  localparam int T_AB = 36;
  localparam int T_C  = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic                        ab_valid_i, ab_ready_i;
  logic [7:0][1:0][15:0]       ab_data_i;
  logic [3:0][2:0][1:0][15:0]  ab_kernel_i;
  logic [3:0][15:0]            ab_bias_i;
  logic                        a_ready_o, a_valid_o, b_ready_o, b_valid_o;
  logic [3:0][5:0][15:0]       a_data_o, b_data_o;

  logic                        c_valid_i, c_ready_i, c_ready_o, c_valid_o;
  logic [8:0][1:0][15:0]       c_data_i;
  logic [3:0][2:0][1:0][15:0]  c_kernel_i;
  logic [3:0][15:0]            c_bias_i;
  logic [3:0][3:0][15:0]       c_data_o;

  conv_layer_stream dut_a (
    .clk_i(clk), .reset_i(rst), .valid_i(ab_valid_i), .ready_o(a_ready_o),
    .data_i(ab_data_i), .kernel_i(ab_kernel_i), .bias_i(ab_bias_i),
    .valid_o(a_valid_o), .ready_i(ab_ready_i), .data_o(a_data_o));

  conv_layer_stream #(.RELU(0)) dut_b (
    .clk_i(clk), .reset_i(rst), .valid_i(ab_valid_i), .ready_o(b_ready_o),
    .data_i(ab_data_i), .kernel_i(ab_kernel_i), .bias_i(ab_bias_i),
    .valid_o(b_valid_o), .ready_i(ab_ready_i), .data_o(b_data_o));

  conv_layer_stream #(.INPUT_LAYER_HEIGHT(9), .STRIDE(2)) dut_c (
    .clk_i(clk), .reset_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o),
    .data_i(c_data_i), .kernel_i(c_kernel_i), .bias_i(c_bias_i),
    .valid_o(c_valid_o), .ready_i(c_ready_i), .data_o(c_data_o));

  // Reference stimulus and expected results (relu off / relu on).
  word_t m_data   [16][2];
  word_t m_kernel [4][3][2];
  word_t m_bias   [4];
  word_t exp_r0   [4][8];
  word_t exp_r1   [4][8];

  function automatic word_t rnd(input int mag);
    if (mag == 0) return word_t'($urandom);
    return word_t'(int'($urandom_range(2 * mag, 0)) - mag);
  endfunction

  task automatic fill_const(input word_t d, input word_t k, input word_t b);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 2; c++) m_data[r][c] = d;
    for (int f = 0; f < 4; f++) begin
      m_bias[f] = b;
      for (int kk = 0; kk < 3; kk++) for (int c = 0; c < 2; c++) m_kernel[f][kk][c] = k;
    end
  endtask

  task automatic fill_rand(input int mag);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 2; c++) m_data[r][c] = rnd(mag);
    for (int f = 0; f < 4; f++) begin
      m_bias[f] = rnd(mag);
      for (int kk = 0; kk < 3; kk++) for (int c = 0; c < 2; c++) m_kernel[f][kk][c] = rnd(mag);
    end
  endtask

  // y[f][p] = clamp(floor((bias*2^8 + sum data*kernel) / 2^8)), then ReLU variant.
  task automatic model(input int ih, input int stride);
    int     oh;
    longint acc, v;
    oh = (ih - 3) / stride + 1;
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < oh; p++) begin
        acc = longint'(m_bias[f]) * 256;
        for (int kk = 0; kk < 3; kk++)
          for (int c = 0; c < 2; c++)
            acc += longint'(m_data[p * stride + kk][c]) * longint'(m_kernel[f][kk][c]);
        v = acc >>> 8;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        exp_r0[f][p] = word_t'(v);
        exp_r1[f][p] = (v < 0) ? word_t'(0) : word_t'(v);
      end
    end
  endtask

  task automatic drive_ab();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 2; c++) ab_data_i[r][c] = m_data[r][c];
    for (int f = 0; f < 4; f++) begin
      ab_bias_i[f] = m_bias[f];
      for (int kk = 0; kk < 3; kk++) for (int c = 0; c < 2; c++) ab_kernel_i[f][kk][c] = m_kernel[f][kk][c];
    end
  endtask

  task automatic drive_c();
    for (int r = 0; r < 9; r++) for (int c = 0; c < 2; c++) c_data_i[r][c] = m_data[r][c];
    for (int f = 0; f < 4; f++) begin
      c_bias_i[f] = m_bias[f];
      for (int kk = 0; kk < 3; kk++) for (int c = 0; c < 2; c++) c_kernel_i[f][kk][c] = m_kernel[f][kk][c];
    end
  endtask

  // Push one frame through dut_a/dut_b, check latency, busy flag and results.
  task automatic run_ab(input string name, input bit do_release);
    int lat_a, lat_b, busy_err;
    drive_ab();
    model(8, 1);
    @(negedge clk);
    n_checks++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before_accept: got a=%b b=%b expected 1", name, a_ready_o, b_ready_o);
    end
    ab_valid_i = 1'b1;
    @(posedge clk); #1;
    ab_valid_i = 1'b0;
    lat_a = -1; lat_b = -1; busy_err = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (lat_a < 0 && a_valid_o === 1'b1) lat_a = cyc;
      if (lat_b < 0 && b_valid_o === 1'b1) lat_b = cyc;
      if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0) busy_err++;
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    n_checks++;
    if (lat_a != T_AB) begin n_fail++; $display("FAIL %s latency_a: got %0d expected %0d", name, lat_a, T_AB); end
    n_checks++;
    if (lat_b != T_AB) begin n_fail++; $display("FAIL %s latency_b: got %0d expected %0d", name, lat_b, T_AB); end
    n_checks++;
    if (busy_err != 0) begin n_fail++; $display("FAIL %s ready_low_while_busy: got %0d high cycles expected 0", name, busy_err); end
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 6; p++) begin
        n_checks++;
        if (a_data_o[f][p] !== exp_r1[f][p]) begin
          n_fail++; $display("FAIL %s a_data[%0d][%0d]: got %h expected %h", name, f, p, a_data_o[f][p], exp_r1[f][p]);
        end
        n_checks++;
        if (b_data_o[f][p] !== exp_r0[f][p]) begin
          n_fail++; $display("FAIL %s b_data[%0d][%0d]: got %h expected %h", name, f, p, b_data_o[f][p], exp_r0[f][p]);
        end
      end
    end
    if (do_release) begin
      @(negedge clk); ab_ready_i = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0 || a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL %s release: got valid a=%b b=%b ready a=%b b=%b expected valid 0 ready 1",
                           name, a_valid_o, b_valid_o, a_ready_o, b_ready_o);
      end
      @(negedge clk); ab_ready_i = 1'b0;
    end
  endtask

  task automatic run_c(input string name);
    int lat;
    drive_c();
    model(9, 2);
    @(negedge clk); c_valid_i = 1'b1;
    @(posedge clk); #1;
    c_valid_i = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (c_valid_o === 1'b1) begin lat = cyc; break; end
    end
    n_checks++;
    if (lat != T_C) begin n_fail++; $display("FAIL %s latency_c: got %0d expected %0d", name, lat, T_C); end
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (c_data_o[f][p] !== exp_r1[f][p]) begin
          n_fail++; $display("FAIL %s c_data[%0d][%0d]: got %h expected %h", name, f, p, c_data_o[f][p], exp_r1[f][p]);
        end
      end
    end
    @(negedge clk); c_ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (c_valid_o !== 1'b0 || c_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s release_c: got valid=%b ready=%b expected 0 1", name, c_valid_o, c_ready_o);
    end
    @(negedge clk); c_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0 || c_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b%b%b expected 000", a_valid_o, b_valid_o, c_valid_o);
    end
    n_checks++;
    if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0 || c_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b%b expected 000", a_ready_o, b_ready_o, c_ready_o);
    end
    n_checks++;
    if (a_data_o !== '0 || b_data_o !== '0 || c_data_o !== '0) begin
      n_fail++; $display("FAIL reset_data: got a=%h expected 0", a_data_o);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1 || c_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b%b%b expected 111", a_ready_o, b_ready_o, c_ready_o);
    end
  endtask

  task automatic test_basic();
    fill_const(16'h0100, 16'h0100, 16'h0000);
    run_ab("basic", 1'b1);
    n_checks++;
    if (a_data_o[3][5] !== 16'h0600) begin
      n_fail++; $display("FAIL basic_literal: got %h expected 0600", a_data_o[3][5]);
    end
  endtask

  task automatic test_saturation();
    fill_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_ab("sat_pos", 1'b1);
    n_checks++;
    if (b_data_o[1][2] !== 16'h7FFF) begin
      n_fail++; $display("FAIL sat_pos_literal: got %h expected 7fff", b_data_o[1][2]);
    end
    fill_const(16'h7FFF, 16'h8000, 16'h7FFF);
    run_ab("sat_neg", 1'b1);
    n_checks++;
    if (b_data_o[0][0] !== 16'h8000 || a_data_o[0][0] !== 16'h0000) begin
      n_fail++; $display("FAIL sat_neg_literal: got b=%h a=%h expected 8000 0000", b_data_o[0][0], a_data_o[0][0]);
    end
  endtask

  task automatic test_floor();
    fill_const(16'h0000, 16'h0000, 16'h0000);
    m_data[0][0] = 16'h0001;
    for (int f = 0; f < 4; f++) m_kernel[f][0][0] = 16'hFFFF;
    run_ab("floor", 1'b1);
    n_checks++;
    if (b_data_o[2][0] !== 16'hFFFF || b_data_o[2][1] !== 16'h0000) begin
      n_fail++; $display("FAIL floor_literal: got %h %h expected ffff 0000", b_data_o[2][0], b_data_o[2][1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      fill_rand((i < 2) ? 600 : 0);
      run_ab("random", 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0][5:0][15:0] snap_a, snap_b;
    fill_rand(400);
    run_ab("backpressure", 1'b0);
    snap_a = a_data_o;
    snap_b = b_data_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ab_valid_i = (i % 2 == 0);
      for (int r = 0; r < 8; r++) for (int c = 0; c < 2; c++) ab_data_i[r][c] = 16'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (a_valid_o !== 1'b1 || b_valid_o !== 1'b1 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_flags cycle %0d: got valid %b%b ready %b%b expected 11 00",
                           i, a_valid_o, b_valid_o, a_ready_o, b_ready_o);
      end
      n_checks++;
      if (a_data_o !== snap_a || b_data_o !== snap_b) begin
        n_fail++; $display("FAIL bp_hold_data cycle %0d: got %h expected %h", i, a_data_o, snap_a);
      end
    end
    @(negedge clk); ab_valid_i = 1'b1; ab_ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1 || b_valid_o !== 1'b0 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid %b%b ready %b%b expected 00 11", a_valid_o, b_valid_o, a_ready_o, b_ready_o);
    end
    @(negedge clk); ab_valid_i = 1'b0; ab_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_no_accept cycle %0d: got ready=%b valid=%b expected 1 0", i, a_ready_o, a_valid_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r1, r2, highs, bad;
    fill_rand(300);
    drive_ab();
    model(8, 1);
    r1 = -1; r2 = -1; highs = 0;
    @(negedge clk); ab_valid_i = 1'b1; ab_ready_i = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      if (a_valid_o === 1'b1) begin
        highs++;
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) begin r2 = cyc; ab_valid_i = 1'b0; end
        bad = 0;
        for (int f = 0; f < 4; f++) for (int p = 0; p < 6; p++) if (a_data_o[f][p] !== exp_r1[f][p]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_data at cycle %0d: got %0d wrong words expected 0", cyc, bad); end
      end
    end
    ab_valid_i = 1'b0; ab_ready_i = 1'b0;
    n_checks++;
    if (r1 != T_AB) begin n_fail++; $display("FAIL b2b_first_valid: got %0d expected %0d", r1, T_AB); end
    n_checks++;
    if (r2 != 2 * T_AB + 2) begin n_fail++; $display("FAIL b2b_second_valid: got %0d expected %0d", r2, 2 * T_AB + 2); end
    n_checks++;
    if (highs != 2) begin n_fail++; $display("FAIL b2b_valid_cycles: got %0d expected 2", highs); end
  endtask

  task automatic test_reset_mid();
    fill_const(16'h0100, 16'h0100, 16'h0000);
    drive_ab();
    @(negedge clk); ab_valid_i = 1'b1;
    @(posedge clk); #1;
    ab_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags: got valid %b%b ready %b%b expected 00 00", a_valid_o, b_valid_o, a_ready_o, b_ready_o);
    end
    n_checks++;
    if (a_data_o !== '0 || b_data_o !== '0) begin
      n_fail++; $display("FAIL midreset_data: got %h expected 0", a_data_o);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++;
    if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_release: got ready=%b valid=%b expected 1 0", a_ready_o, a_valid_o);
    end
    run_ab("after_reset", 1'b1);
    n_checks++;
    if (a_data_o[0][0] !== 16'h0600) begin
      n_fail++; $display("FAIL after_reset_literal: got %h expected 0600", a_data_o[0][0]);
    end
  endtask

  task automatic test_stride();
    word_t exp_lit [4];
    exp_lit = '{16'h0600, 16'h1200, 16'h1E00, 16'h2A00};
    fill_const(16'h0000, 16'h0100, 16'h0000);
    for (int r = 0; r < 9; r++) for (int c = 0; c < 2; c++) m_data[r][c] = word_t'(r * 256);
    run_c("stride");
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (c_data_o[1][p] !== exp_lit[p]) begin
        n_fail++; $display("FAIL stride_literal[%0d]: got %h expected %h", p, c_data_o[1][p], exp_lit[p]);
      end
    end
    fill_rand(500);
    run_c("stride_random");
  endtask

  initial begin
    rst = 1'b0;
    ab_valid_i = 1'b0; ab_ready_i = 1'b0;
    ab_data_i = '0; ab_kernel_i = '0; ab_bias_i = '0;
    c_valid_i = 1'b0; c_ready_i = 1'b0;
    c_data_i = '0; c_kernel_i = '0; c_bias_i = '0;
    #1 rst = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_floor();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_stride();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
